// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand path. It holds the element and bus
// geometry, the loader state encoding and the element bit-offset helper.
package matrix_pkg;
  localparam int ELEM_W   = 8;
  localparam int DIM      = 5;
  localparam int MAT_W    = DIM * DIM * ELEM_W;
  localparam int SIZE_MIN = 2;
  localparam int SIZE_MAX = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } ld_state_e;

  function automatic int elem_lsb(input logic [2:0] row, input logic [2:0] col);
    return (int'(row) * DIM + int'(col)) * ELEM_W;
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row,col) walker over an N x N matrix. A single instance serves both load phases,
// and the owner clears it between phases.
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic [2:0] size,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [2:0] lim;

  assign lim = size - 3'd1;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (col_q == lim) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == lim) && (col_q == lim);
endmodule

// File: rtl/matrix_operand_loader.sv
// Loads matrix A and then matrix B from a byte stream into packed DIMxDIM buses. It holds
// both buses stable for the combinational matrix units until the consumer acknowledges.
module matrix_operand_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mat_size,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MAT_W-1:0]  matrix_A,
  output logic [MAT_W-1:0]  matrix_B,
  output logic              mats_valid,
  input  logic              mats_ack,
  output logic              busy,
  output logic              size_err
);
  ld_state_e        state_q, state_d;
  logic [2:0]       size_q, size_d;
  logic [MAT_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic             in_ready_q, in_ready_d;
  logic             mats_valid_q, mats_valid_d;
  logic             busy_q, busy_d;
  logic             size_err_q, size_err_d;
  logic             beat, clr, step;
  logic [2:0]       row, col;
  logic             last;

  assign beat = in_valid && in_ready_q;
  assign step = beat && (state_q == ST_LOAD_A || state_q == ST_LOAD_B);

  matrix_index_counter u_idx (
    .clk  (clk),
    .rst  (rst),
    .clear(clr),
    .step (step),
    .size (size_q),
    .row  (row),
    .col  (col),
    .last (last)
  );

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    size_err_d = 1'b0;
    clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mat_size >= 3'(SIZE_MIN) && mat_size <= 3'(SIZE_MAX)) begin
            size_d  = mat_size;
            mat_a_d = '0;
            mat_b_d = '0;
            clr     = 1'b1;
            state_d = ST_LOAD_A;
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      ST_LOAD_A: begin
        if (beat) begin
          mat_a_d[elem_lsb(row, col) +: ELEM_W] = in_data;
          // B reuses the same walker, so restart it at (0,0).
          if (last) begin
            state_d = ST_LOAD_B;
            clr     = 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (beat) begin
          mat_b_d[elem_lsb(row, col) +: ELEM_W] = in_data;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (mats_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d   = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    mats_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      size_q       <= 3'(SIZE_MAX);
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      in_ready_q   <= 1'b0;
      mats_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      in_ready_q   <= in_ready_d;
      mats_valid_q <= mats_valid_d;
      busy_q       <= busy_d;
      size_err_q   <= size_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign matrix_A   = mat_a_q;
  assign matrix_B   = mat_b_q;
  assign mats_valid = mats_valid_q;
  assign busy       = busy_q;
  assign size_err   = size_err_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomized and directed bench for matrix_operand_loader. The buses are compared against
// the source element arrays, which are packed by plain row-major arithmetic.
module tb_matrix_operand_loader;
  import matrix_pkg::*;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, mats_ack = 1'b0;
  logic [2:0]        mat_size = '0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_ready, mats_valid, busy, size_err;
  logic [MAT_W-1:0]  matrix_A, matrix_B;

  int  total = 0, bad = 0;
  byte src_a[25], src_b[25];

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk(clk), .rst(rst), .start(start), .mat_size(mat_size), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .matrix_A(matrix_A), .matrix_B(matrix_B),
    .mats_valid(mats_valid), .mats_ack(mats_ack), .busy(busy), .size_err(size_err)
  );

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] exp_bus(input int n, input bit is_b);
    logic [MAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        v[(i*DIM+j)*ELEM_W +: ELEM_W] = is_b ? src_b[i*n+j] : src_a[i*n+j];
    return v;
  endfunction

  // mode 0: always valid, 1: every other cycle, 2: random gaps
  task automatic feed(input int n, input int mode, input int stop, output int cycles, output bit early);
    int idx;
    bit v, ph;
    idx = 0; ph = 0; early = 0;
    @(negedge clk); start = 1'b1; mat_size = 3'(n);
    @(negedge clk); start = 1'b0; cycles = 1;
    while (idx < stop && cycles < 3000) begin
      if (mats_valid) early = 1;
      case (mode)
        0: v = 1'b1;
        1: begin v = ph; ph = !ph; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = (idx < n*n) ? src_a[idx] : src_b[idx-n*n];
      if (v && in_ready) idx++;
      @(negedge clk); cycles++;
    end
    in_valid = 1'b0;
    if (idx < stop) chk("feed_timeout", MAT_W'(idx), MAT_W'(stop));
  endtask

  task automatic check_done(input int n, input string t);
    chk({t, "_valid"}, MAT_W'(mats_valid), 1);
    chk({t, "_ready"}, MAT_W'(in_ready), 0);
    chk({t, "_busy"},  MAT_W'(busy), 1);
    chk({t, "_A"}, matrix_A, exp_bus(n, 0));
    chk({t, "_B"}, matrix_B, exp_bus(n, 1));
  endtask

  task automatic do_ack(input int n, input string t);
    mats_ack = 1'b1;
    @(negedge clk); mats_ack = 1'b0;
    chk({t, "_ack_valid"}, MAT_W'(mats_valid), 0);
    chk({t, "_ack_busy"},  MAT_W'(busy), 0);
    chk({t, "_ack_A"}, matrix_A, exp_bus(n, 0));
  endtask

  task automatic check_idle_zero(input string t);
    chk({t, "_ready"}, MAT_W'(in_ready), 0);
    chk({t, "_valid"}, MAT_W'(mats_valid), 0);
    chk({t, "_busy"},  MAT_W'(busy), 0);
    chk({t, "_err"},   MAT_W'(size_err), 0);
    chk({t, "_A"}, matrix_A, '0);
    chk({t, "_B"}, matrix_B, '0);
  endtask

  initial begin
    int  cyc, n, dly;
    bit  early;
    logic [MAT_W-1:0] hold_a, hold_b;
    logic [2:0] bad_sz[4];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    // Illegal sizes: one-cycle size_err, nothing else moves
    bad_sz = '{3'd1, 3'd6, 3'd0, 3'd7};
    for (int k = 0; k < 4; k++) begin
      start = 1'b1; mat_size = bad_sz[k];
      @(negedge clk); start = 1'b0;
      chk("illegal_err", MAT_W'(size_err), 1);
      chk("illegal_busy", MAT_W'(busy), 0);
      chk("illegal_ready", MAT_W'(in_ready), 0);
      @(negedge clk);
      chk("illegal_err_drop", MAT_W'(size_err), 0);
      chk("illegal_A", matrix_A, '0);
    end

    // 5x5 back-to-back
    for (int k = 0; k < 25; k++) begin src_a[k] = byte'(10*(k+1)); src_b[k] = byte'(k+1); end
    feed(5, 0, 50, cyc, early);
    chk("t1_cycles", MAT_W'(cyc), 51);
    chk("t1_early", MAT_W'(early), 0);
    check_done(5, "t1");
    chk("t1_a0", MAT_W'(matrix_A[7:0]), 10);
    chk("t1_a24", MAT_W'(matrix_A[199:192]), 250);
    chk("t1_b24", MAT_W'(matrix_B[199:192]), 25);
    for (int k = 0; k < 25; k++)
      chk("t1_sub", MAT_W'(8'(matrix_A[k*8 +: 8] - matrix_B[k*8 +: 8])), MAT_W'(9*(k+1)));
    do_ack(5, "t1");

    // 3x3 with zero fill; the start must clear the previous 5x5 contents
    for (int k = 0; k < 9; k++) begin src_a[k] = byte'(k+1); src_b[k] = byte'(9-k); end
    feed(3, 0, 18, cyc, early);
    chk("t2_cycles", MAT_W'(cyc), 19);
    check_done(3, "t2");
    chk("t2_a10", MAT_W'(matrix_A[47:40]), 4);
    chk("t2_a22", MAT_W'(matrix_A[103:96]), 9);
    do_ack(3, "t2");

    // gapped stream of negative values
    for (int k = 0; k < 25; k++) begin src_a[k] = byte'(-5*(k+1)); src_b[k] = byte'(-5*(k+26)); end
    feed(5, 1, 50, cyc, early);
    chk("t3_early", MAT_W'(early), 0);
    chk("t3_cycles_range", MAT_W'(cyc >= 95 && cyc <= 110), 1);
    check_done(5, "t3");
    chk("t3_byte0", MAT_W'(matrix_A[7:0]), 8'hFB);
    do_ack(5, "t3");

    // reset mid-load, then a fresh 2x2
    feed(5, 0, 20, cyc, early);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle_zero("t5_rst");
    for (int k = 0; k < 4; k++) begin src_a[k] = byte'($urandom); src_b[k] = byte'($urandom); end
    feed(2, 0, 8, cyc, early);
    chk("t5_cycles", MAT_W'(cyc), 9);
    check_done(2, "t5");
    do_ack(2, "t5");

    // hold in DONE: stray valid and start are ignored, including start with ack
    for (int k = 0; k < 25; k++) begin src_a[k] = 8'sd127; src_b[k] = -8'sd128; end
    feed(5, 0, 50, cyc, early);
    check_done(5, "t6");
    hold_a = matrix_A; hold_b = matrix_B;
    in_valid = 1'b1; in_data = 8'h55; start = 1'b1; mat_size = 3'd3;
    repeat (3) @(negedge clk);
    chk("t6_ready", MAT_W'(in_ready), 0);
    chk("t6_valid", MAT_W'(mats_valid), 1);
    chk("t6_A_hold", matrix_A, exp_bus(5, 0));
    chk("t6_B_hold", matrix_B, exp_bus(5, 1));
    mats_ack = 1'b1;
    @(negedge clk); mats_ack = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("t6_ack_valid", MAT_W'(mats_valid), 0);
    chk("t6_ack_busy", MAT_W'(busy), 0);
    chk("t6_ack_A", matrix_A, exp_bus(5, 0));
    chk("t6_ack_B", matrix_B, exp_bus(5, 1));
    start = 1'b1; mat_size = 3'd4;
    @(negedge clk); start = 1'b0;
    chk("t6_clr_A", matrix_A, '0);
    chk("t6_clr_B", matrix_B, '0);
    chk("t6_clr_busy", MAT_W'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // random sizes, data, gaps and ack delay
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(2, 5);
      for (int k = 0; k < 25; k++) begin src_a[k] = byte'($urandom); src_b[k] = byte'($urandom); end
      feed(n, 2, 2*n*n, cyc, early);
      chk("rnd_early", MAT_W'(early), 0);
      check_done(n, "rnd");
      dly = $urandom_range(0, 4);
      repeat (dly) @(negedge clk);
      chk("rnd_hold_valid", MAT_W'(mats_valid), 1);
      do_ack(n, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
